// File: rtl/xctcmsg_piton_pkg.sv
// Shared types and sizing helpers for the xctcmsg <-> OpenPiton NoC adapters.
package xctcmsg_piton_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2
   } ser_state_e;

   localparam int DEF_FLIT_WIDTH    = 64;
   localparam int DEF_PAYLOAD_WIDTH = 128;
   localparam int DEF_CHIPID_WIDTH  = 14;
   localparam int DEF_X_WIDTH       = 8;
   localparam int DEF_Y_WIDTH       = 8;
   localparam int DEF_FBITS_WIDTH   = 4;
   localparam int DEF_LENGTH_WIDTH  = 8;

   function automatic int payload_flits(input int payload_width, input int flit_width);
      return payload_width / flit_width;
   endfunction

   function automatic int reserved_width(input int flit_width, input int chipid_width,
                                         input int x_width, input int y_width,
                                         input int fbits_width, input int length_width);
      return flit_width - chipid_width - x_width - y_width - fbits_width - length_width;
   endfunction

   // Header layout for the default field widths, chipid in the MSBs.
   typedef struct packed {
      logic [DEF_CHIPID_WIDTH-1:0] chipid;
      logic [DEF_X_WIDTH-1:0]      x;
      logic [DEF_Y_WIDTH-1:0]      y;
      logic [DEF_FBITS_WIDTH-1:0]  fbits;
      logic [DEF_LENGTH_WIDTH-1:0] length;
      logic [21:0]                 reserved;
   } hdr_default_t;

endpackage

// File: rtl/xctcmsg_piton_noc_serializer.sv
// Transmit serializer: one message per handshake, streamed as header + N payload flits.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no message held, ready to accept
// ST_HEADER  | header flit offered on the NoC
// ST_PAYLOAD | payload flit k offered on the NoC, lowest flit first
module xctcmsg_piton_noc_serializer
   import xctcmsg_piton_pkg::*;
#(
   parameter int FLIT_WIDTH    = DEF_FLIT_WIDTH,
   parameter int PAYLOAD_WIDTH = DEF_PAYLOAD_WIDTH,
   parameter int CHIPID_WIDTH  = DEF_CHIPID_WIDTH,
   parameter int X_WIDTH       = DEF_X_WIDTH,
   parameter int Y_WIDTH       = DEF_Y_WIDTH,
   parameter int FBITS_WIDTH   = DEF_FBITS_WIDTH,
   parameter int LENGTH_WIDTH  = DEF_LENGTH_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     msg_valid_i,
   output logic                     msg_ready_o,
   input  logic [CHIPID_WIDTH-1:0]  dst_chipid_i,
   input  logic [X_WIDTH-1:0]       dst_x_i,
   input  logic [Y_WIDTH-1:0]       dst_y_i,
   input  logic [FBITS_WIDTH-1:0]   dst_fbits_i,
   input  logic [PAYLOAD_WIDTH-1:0] payload_i,
   input  logic [LENGTH_WIDTH-1:0]  payload_flits_i,
   output logic                     noc_valid_o,
   output logic [FLIT_WIDTH-1:0]    noc_data_o,
   input  logic                     noc_ready_i,
   output logic                     busy_o,
   output logic                     err_len_o
);

   localparam int PAYLOAD_FLITS  = payload_flits(PAYLOAD_WIDTH, FLIT_WIDTH);
   localparam int RESERVED_WIDTH = reserved_width(FLIT_WIDTH, CHIPID_WIDTH, X_WIDTH,
                                                  Y_WIDTH, FBITS_WIDTH, LENGTH_WIDTH);
   localparam int RSV_SHIFT      = (RESERVED_WIDTH < 0) ? 0 : RESERVED_WIDTH;
   localparam int FIELDS_WIDTH   = CHIPID_WIDTH + X_WIDTH + Y_WIDTH + FBITS_WIDTH + LENGTH_WIDTH;
   localparam int KW             = $clog2(PAYLOAD_FLITS + 1);

   if (RESERVED_WIDTH < 0) begin : g_bad_header
      $error("header fields do not fit in one flit");
   end
   if ((PAYLOAD_WIDTH % FLIT_WIDTH) != 0) begin : g_bad_payload
      $error("payload width is not a whole number of flits");
   end

   ser_state_e               state_q, state_d;
   logic [FLIT_WIDTH-1:0]    header_q, header_d;
   logic [PAYLOAD_WIDTH-1:0] payload_q, payload_d;
   logic [KW-1:0]            len_q, len_d;
   logic [KW-1:0]            k_q, k_d;
   logic                     err_len_q, err_len_d;

   logic                     last_hs;
   logic                     accept;
   logic                     clamp;
   logic [KW-1:0]            len_acc;
   logic [FIELDS_WIDTH-1:0]  fields;

   // State and capture registers; reset drops any message in flight.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         header_q  <= '0;
         payload_q <= '0;
         len_q     <= '0;
         k_q       <= '0;
         err_len_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         header_q  <= header_d;
         payload_q <= payload_d;
         len_q     <= len_d;
         k_q       <= k_d;
         err_len_q <= err_len_d;
      end
   end

   // Next state: advance on flit handshakes, capture a new message whenever one is accepted.
   always_comb begin
      state_d   = state_q;
      header_d  = header_q;
      payload_d = payload_q;
      len_d     = len_q;
      k_d       = k_q;
      err_len_d = 1'b0;
      accept    = msg_valid_i & msg_ready_o;
      clamp     = 32'(payload_flits_i) > PAYLOAD_FLITS;
      len_acc   = clamp ? KW'(PAYLOAD_FLITS) : KW'(payload_flits_i);
      fields    = {dst_chipid_i, dst_x_i, dst_y_i, dst_fbits_i, LENGTH_WIDTH'(len_acc)};

      unique case (state_q)
         ST_HEADER: begin
            if (noc_ready_i && (len_q != '0)) begin
               state_d = ST_PAYLOAD;
               k_d     = '0;
            end
         end
         ST_PAYLOAD: begin
            if (noc_ready_i) k_d = k_q + KW'(1);
         end
         default: ;
      endcase

      if (last_hs) state_d = ST_IDLE;

      // A new accept overrides the return to idle so back-to-back messages have no bubble.
      if (accept) begin
         state_d   = ST_HEADER;
         header_d  = FLIT_WIDTH'(fields) << RSV_SHIFT;
         payload_d = payload_i;
         len_d     = len_acc;
         k_d       = '0;
         err_len_d = clamp;
      end
   end

   // Outputs: flit mux, handshake-driven ready, status flags.
   always_comb begin
      msg_ready_o = 1'b0;
      noc_valid_o = 1'b0;
      noc_data_o  = '0;
      last_hs     = 1'b0;
      busy_o      = (state_q != ST_IDLE);
      err_len_o   = err_len_q;
      unique case (state_q)
         ST_IDLE: msg_ready_o = 1'b1;
         ST_HEADER: begin
            noc_valid_o = 1'b1;
            noc_data_o  = header_q;
            last_hs     = noc_ready_i && (len_q == '0);
         end
         ST_PAYLOAD: begin
            noc_valid_o = 1'b1;
            noc_data_o  = payload_q[k_q*FLIT_WIDTH +: FLIT_WIDTH];
            last_hs     = noc_ready_i && (k_q == len_q - KW'(1));
         end
         default: ;
      endcase
      msg_ready_o = msg_ready_o | last_hs;
   end

endmodule

// File: tb/tb_xctcmsg_piton_noc_serializer.sv
// Randomized + directed bench for the NoC serializer against a flit-queue reference model.
module tb_xctcmsg_piton_noc_serializer;

   logic         clk = 1'b0;
   logic         rst_ni;
   logic         msg_valid_i;
   logic         msg_ready_o;
   logic [13:0]  dst_chipid_i;
   logic [7:0]   dst_x_i, dst_y_i;
   logic [3:0]   dst_fbits_i;
   logic [127:0] payload_i;
   logic [7:0]   payload_flits_i;
   logic         noc_valid_o;
   logic [63:0]  noc_data_o;
   logic         noc_ready_i;
   logic         busy_o, err_len_o;

   logic         w_valid, w_ready, w_noc_valid, w_busy, w_err;
   logic [255:0] w_payload;
   logic [63:0]  w_data;

   int n_chk = 0;
   int n_pass = 0;
   int rdy_mode = 0;
   int pat = 0;
   logic [63:0] exp_q[$];
   logic [63:0] wq[$];
   logic err_pend = 1'b0;
   logic exp_err;
   logic exp_rdy;

   always #5 clk = ~clk;

   xctcmsg_piton_noc_serializer dut (
      .clk_i(clk), .rst_ni(rst_ni), .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
      .dst_chipid_i(dst_chipid_i), .dst_x_i(dst_x_i), .dst_y_i(dst_y_i),
      .dst_fbits_i(dst_fbits_i), .payload_i(payload_i), .payload_flits_i(payload_flits_i),
      .noc_valid_o(noc_valid_o), .noc_data_o(noc_data_o), .noc_ready_i(noc_ready_i),
      .busy_o(busy_o), .err_len_o(err_len_o)
   );

   xctcmsg_piton_noc_serializer #(.PAYLOAD_WIDTH(256)) dut_w (
      .clk_i(clk), .rst_ni(rst_ni), .msg_valid_i(w_valid), .msg_ready_o(w_ready),
      .dst_chipid_i(14'd5), .dst_x_i(8'd1), .dst_y_i(8'd7), .dst_fbits_i(4'd2),
      .payload_i(w_payload), .payload_flits_i(8'd4),
      .noc_valid_o(w_noc_valid), .noc_data_o(w_data), .noc_ready_i(1'b1),
      .busy_o(w_busy), .err_len_o(w_err)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
   endtask

   // Header as the NoC sees it: chipid 63:50, x 49:42, y 41:34, fbits 33:30, len 29:22.
   function automatic logic [63:0] mk_hdr(input logic [13:0] c, input logic [7:0] x,
                                          input logic [7:0] y, input logic [3:0] f, input int len);
      return (64'(c) << 50) | (64'(x) << 42) | (64'(y) << 34) | (64'(f) << 30) | (64'(len) << 22);
   endfunction

   task automatic push_msg();
      int len;
      len = (payload_flits_i > 8'd2) ? 2 : int'(payload_flits_i);
      exp_q.push_back(mk_hdr(dst_chipid_i, dst_x_i, dst_y_i, dst_fbits_i, len));
      for (int k = 0; k < len; k++) exp_q.push_back(payload_i[k*64 +: 64]);
      err_pend = (payload_flits_i > 8'd2);
   endtask

   // Monitor: every flit the DUT offers must be the head of the expected-flit queue.
   always @(negedge clk) begin
      if (!rst_ni) begin
         exp_q.delete();
         err_pend = 1'b0;
         chk("rst_valid", 64'(noc_valid_o), 64'd0);
         chk("rst_data", noc_data_o, 64'd0);
         chk("rst_busy", 64'(busy_o), 64'd0);
         chk("rst_err", 64'(err_len_o), 64'd0);
      end else begin
         exp_err  = err_pend;
         err_pend = 1'b0;
         exp_rdy  = (exp_q.size() == 0) || (exp_q.size() == 1 && noc_ready_i);
         chk("busy", 64'(busy_o), 64'(exp_q.size() != 0));
         chk("valid", 64'(noc_valid_o), 64'(exp_q.size() != 0));
         chk("err_len", 64'(err_len_o), 64'(exp_err));
         chk("ready", 64'(msg_ready_o), 64'(exp_rdy));
         if (exp_q.size() != 0) begin
            chk("flit", noc_data_o, exp_q[0]);
            if (noc_ready_i) void'(exp_q.pop_front());
         end
         if (msg_valid_i && exp_rdy) push_msg();
      end
   end

   // NoC back-pressure: always ready, random, or the 0,0,1 stall pattern.
   initial begin
      noc_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            1: noc_ready_i = ($urandom % 3) != 0;
            2: begin
               noc_ready_i = (pat == 2);
               pat = (pat + 1) % 3;
            end
            default: noc_ready_i = 1'b1;
         endcase
      end
   end

   // Offer a message (caller is at posedge+1); returns at posedge+1 after the accept edge.
   task automatic send(input logic [13:0] c, input logic [7:0] x, input logic [7:0] y,
                       input logic [3:0] f, input logic [7:0] pf, input logic [127:0] p,
                       input bit keep);
      bit got;
      dst_chipid_i = c; dst_x_i = x; dst_y_i = y; dst_fbits_i = f;
      payload_flits_i = pf; payload_i = p; msg_valid_i = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         got = msg_ready_o;
      end
      if (!got) chk("accept_timeout", 64'(msg_ready_o), 64'd1);
      @(posedge clk);
      #1;
      if (!keep) msg_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [127:0] rp;
      bit kp;
      rst_ni = 1'b1; msg_valid_i = 1'b0; dst_chipid_i = '0; dst_x_i = '0; dst_y_i = '0;
      dst_fbits_i = '0; payload_i = '0; payload_flits_i = '0;
      w_valid = 1'b0; w_payload = '0;
      #2 rst_ni = 1'b0;
      idle(2);
      rst_ni = 1'b1;
      idle(1);

      send(14'd0, 8'd3, 8'd2, 4'd0, 8'd2, {{16{4'h1}}, {16{4'h2}}}, 1'b0);
      @(negedge clk);
      chk("tp1_hdr", noc_data_o, 64'h00000C0800800000);
      idle(3);

      send(14'h1ABC, 8'h55, 8'hAA, 4'h9, 8'd0, 128'hDEAD, 1'b0);
      idle(2);
      send(14'h0123, 8'h10, 8'h20, 4'h3, 8'd5, {64'hCAFE0000CAFE0001, 64'hBEEF0000BEEF0001}, 1'b0);
      idle(4);

      rdy_mode = 2;
      send(14'h0042, 8'h01, 8'h02, 4'h1, 8'd2, {64'hA5A5A5A5A5A5A5A5, 64'h5A5A5A5A5A5A5A5A}, 1'b0);
      idle(12);
      rdy_mode = 0;

      send(14'h0001, 8'h11, 8'h22, 4'h4, 8'd2, {64'h0000000000000B01, 64'h0000000000000B00}, 1'b1);
      send(14'h0002, 8'h33, 8'h44, 4'h5, 8'd2, {64'h0000000000000C01, 64'h0000000000000C00}, 1'b0);
      idle(4);

      send(14'h0003, 8'h66, 8'h77, 4'h6, 8'd2, {64'h1, 64'h2}, 1'b0);
      idle(1);
      rst_ni = 1'b0;
      idle(2);
      rst_ni = 1'b1;
      send(14'h0004, 8'h88, 8'h99, 4'h7, 8'd1, {64'h3, 64'h4}, 1'b0);
      idle(3);

      rdy_mode = 1;
      for (int i = 0; i < 40; i++) begin
         rp = {$urandom, $urandom, $urandom, $urandom};
         kp = (i != 39) && (($urandom % 4) == 0);
         send(14'($urandom), 8'($urandom), 8'($urandom), 4'($urandom),
              8'($urandom_range(0, 4)), rp, kp);
         if (!kp) idle($urandom_range(0, 2));
      end
      rdy_mode = 0;
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
      chk("drain", 64'(exp_q.size()), 64'd0);

      // Wider payload instance: four payload flits, ascending order.
      w_payload = {64'h4444444444444444, 64'h3333333333333333,
                   64'h2222222222222222, 64'h1111111111111111};
      wq.push_back(mk_hdr(14'd5, 8'd1, 8'd7, 4'd2, 4));
      for (int k = 0; k < 4; k++) wq.push_back(w_payload[k*64 +: 64]);
      idle(1);
      w_valid = 1'b1;
      @(negedge clk);
      chk("w_ready", 64'(w_ready), 64'd1);
      @(posedge clk);
      #1;
      w_valid = 1'b0;
      for (int c = 0; c < 10 && wq.size() != 0; c++) begin
         @(negedge clk);
         chk("w_valid", 64'(w_noc_valid), 64'd1);
         if (w_noc_valid) begin
            chk("w_flit", w_data, wq[0]);
            void'(wq.pop_front());
         end
         chk("w_err", 64'(w_err), 64'd0);
      end
      chk("w_drain", 64'(wq.size()), 64'd0);
      @(negedge clk);
      chk("w_idle", 64'(w_busy), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/xctcmsg_piton_noc_serializer.md
Name: xctcmsg_piton_noc_serializer

Overview:
Transmit-side serializer between the xctcmsg send unit and an OpenPiton val/rdy NoC port. It accepts one whole message per handshake: destination fields plus a payload of up to PAYLOAD_WIDTH bits. It builds the NoC header flit and streams header + N payload flits at one flit per cycle. It generalises the fixed 64b-header/128b-payload/2-flit format to parametrised flit width and payload depth, with a per-message variable payload length.

Parameters:
FLIT_WIDTH, 64, NoC flit width; header occupies exactly one flit.
PAYLOAD_WIDTH, 128, max payload bits; must be a multiple of FLIT_WIDTH.
CHIPID_WIDTH, 14, dst chipid field width.
X_WIDTH, 8, dst x field width.
Y_WIDTH, 8, dst y field width.
FBITS_WIDTH, 4, dst fbits field width.
LENGTH_WIDTH, 8, header length field width.
Derived: PAYLOAD_FLITS = PAYLOAD_WIDTH/FLIT_WIDTH.
Derived: RESERVED_WIDTH = FLIT_WIDTH-CHIPID-X-Y-FBITS-LENGTH; elaboration error if < 0.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
msg_valid_i  in  1  message offered
msg_ready_o  out  1  message accepted when valid&ready
dst_chipid_i  in  CHIPID_WIDTH  destination chip
dst_x_i  in  X_WIDTH  destination tile x
dst_y_i  in  Y_WIDTH  destination tile y
dst_fbits_i  in  FBITS_WIDTH  destination final-bits
payload_i  in  PAYLOAD_WIDTH  payload; flit k = payload_i[k*FLIT_WIDTH +: FLIT_WIDTH]
payload_flits_i  in  LENGTH_WIDTH  payload flits to send, 0..PAYLOAD_FLITS
noc_valid_o  out  1  flit valid
noc_data_o  out  FLIT_WIDTH  flit data
noc_ready_i  in  1  NoC accepts flit
busy_o  out  1  message in flight
err_len_o  out  1  one-cycle pulse: payload_flits_i out of range at accept

Behaviour:
- Reset (async, rst_ni low): state=IDLE; noc_valid_o=0; noc_data_o=0; busy_o=0; err_len_o=0; capture registers cleared. Reset mid-message drops the message; no further flits are sent.
- FSM states: IDLE, HEADER, PAYLOAD.
- IDLE: msg_ready_o=1. On accept:
  - capture fields and payload;
  - len = payload_flits_i > PAYLOAD_FLITS ? PAYLOAD_FLITS : payload_flits_i; err_len_o=1 next cycle if clamped;
  - go to HEADER.
- HEADER: noc_valid_o=1; noc_data_o = {chipid, x, y, fbits, len, reserved=0}, chipid at MSBs and reserved at LSBs. On noc_ready_i: if len==0, message is done; else go to PAYLOAD with flit index k=0.
- PAYLOAD: noc_valid_o=1; noc_data_o = captured flit k, lowest flit first. On noc_ready_i: k++. When k==len-1 is accepted, message is done.
- Message done:
  - msg_ready_o is asserted combinationally in the same cycle as the last-flit handshake (noc_valid_o & noc_ready_i on the final flit).
  - If msg_valid_i is also high, the new message is captured and the next state is HEADER, giving back-to-back messages with no bubble.
  - Otherwise the next state is IDLE.
- msg_ready_o = (state==IDLE) | last-flit handshake. It has no other combinational dependence on msg_valid_i.
- Flit timing: header is valid the cycle after accept, so acceptance-to-first-flit latency is 1.
- Handshake: once noc_valid_o rises, noc_valid_o and noc_data_o stay stable until noc_ready_i. noc_valid_o is never deasserted without a handshake.
- busy_o = (state != IDLE).
- Width rules: k is a counter of width $clog2(PAYLOAD_FLITS+1). Length in the header is len zero-extended to LENGTH_WIDTH.
- Inputs are sampled only at accept; changes while busy are ignored.

Decomposition:
- xctcmsg_piton_pkg: parametrised header-parts struct/union and PAYLOAD_FLITS/RESERVED_WIDTH helper constants, replacing the fixed 64/128/192 defines. This module uses its widths as defaults.
- No sub-module. An optional receive-side counterpart (xctcmsg_piton_noc_deserializer) is a separate block reusing the same package.

Test Plan:
- Defaults; x=3, y=2, chipid=0, fbits=0, payload_flits=2, payload=0x1111..._2222..., noc_ready_i=1 → flits 0x00000C0800800000, 0x2222222222222222, 0x1111111111111111 on three consecutive cycles starting 1 cycle after accept; busy_o high for those 3 cycles.
- payload_flits=0 → single header flit with length field 0; msg_ready_o high during its handshake.
- payload_flits=5 (PAYLOAD_FLITS=2) → err_len_o pulses once; header length=2; 2 payload flits sent.
- noc_ready_i toggling 0,0,1 per flit → noc_data_o/noc_valid_o stable across stall cycles; no flit dropped or duplicated.
- Two messages back-to-back with msg_valid_i held and ready=1 → 6 contiguous flits with no idle cycle; second accept coincides with the first message's last flit.
- rst_ni low during PAYLOAD flit 0 → noc_valid_o=0 immediately; after release, next accepted message starts with a fresh header.
- FLIT_WIDTH=64, PAYLOAD_WIDTH=256, payload_flits=4 → header length=4, 4 payload flits in ascending order.
